cache_ctrl: RTL and testbench

Sequencing controller for the direct-mapped write-back data cache built from the status/tag RAM and the line data RAM (1-cycle synchronous-read block RAMs, 128-bit lines). Accepts one CPU load/store at a time, performs tag lookup, and on a miss runs the dirty-line writeback and line refill against the memory interface. It drives the RAM control ports directly and sits between the CPU memory stage and the DRAM/AXI bridge.

---
 rtl/cache_ctrl_if.sv | 63 ++++++
 rtl/cache_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// Cache controller bundle: CPU request port, status/tag + data RAM ports, memory bridge port, counters.
// slave = cache controller side, master = environment (CPU stage, RAMs, memory bridge).
interface cache_ctrl_if #(
  parameter int tag_len    = 13,
  parameter int index_len  = 10,
  parameter int offset_len = 4
);
  localparam int addr_len  = tag_len + index_len + offset_len;
  localparam int line_len  = 32 * (2 ** (offset_len - 2));
  localparam int laddr_len = tag_len + index_len;

  logic                 cpu_req;
  logic                 cpu_we;
  logic [addr_len-1:0]  cpu_addr;
  logic [31:0]          cpu_wdata;
  logic                 cpu_ready;
  logic                 cpu_valid;
  logic [31:0]          cpu_rdata;

  logic                 tag_we;
  logic [index_len-1:0] tag_addr;
  logic [tag_len-1:0]   tag_in;
  logic [2:0]           status_in;
  logic [tag_len-1:0]   tag_out;
  logic [2:0]           status_out;

  logic                 data_we;
  logic [index_len-1:0] data_addr;
  logic [line_len-1:0]  data_in;
  logic [line_len-1:0]  data_out;

  logic                 mem_req;
  logic                 mem_we;
  logic [laddr_len-1:0] mem_addr;
  logic [line_len-1:0]  mem_wdata;
  logic                 mem_ack;
  logic [line_len-1:0]  mem_rdata;

  logic [31:0]          hit_cnt;
  logic [31:0]          miss_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  tag_out, status_out, data_out,
    input  mem_ack, mem_rdata,
    output cpu_ready, cpu_valid, cpu_rdata,
    output tag_we, tag_addr, tag_in, status_in,
    output data_we, data_addr, data_in,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output hit_cnt, miss_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output tag_out, status_out, data_out,
    output mem_ack, mem_rdata,
    input  cpu_ready, cpu_valid, cpu_rdata,
    input  tag_we, tag_addr, tag_in, status_in,
    input  data_we, data_addr, data_in,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache sequencer: lookup, dirty writeback, refill. Hit completes 2 cycles after accept.
// One request in flight: cpu_ready low until the completion pulse; mem_req held until mem_ack.
module cache_ctrl #(
  parameter int tag_len    = 13,
  parameter int index_len  = 10,
  parameter int offset_len = 4,
  parameter int cnt_w      = 32
) (
  input  logic        clk,
  input  logic        rst,
  cache_ctrl_if.slave bus
);
  localparam int addr_len  = tag_len + index_len + offset_len;
  localparam int sel_w     = offset_len - 2;
  localparam int words     = 2 ** sel_w;
  localparam int laddr_len = tag_len + index_len;

  typedef logic [words-1:0][31:0] line_t;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, FILL, RESP} state_t;

  state_t               state_q, state_d;
  logic                 req_we_q;
  logic [addr_len-3:0]  req_addr_q;
  logic [31:0]          req_wdata_q;
  line_t                refill_q;
  logic [31:0]          rdata_q;
  logic                 mem_we_q;
  logic [laddr_len-1:0] mem_addr_q;
  line_t                mem_wdata_q;
  logic [cnt_w-1:0]     hit_q, miss_q;

  logic [tag_len-1:0]   req_tag;
  logic [index_len-1:0] req_index, cpu_index;
  logic [sel_w-1:0]     req_sel;
  line_t                rd_line, merged_rd, merged_refill;
  logic                 hit, dirty;

  // Latched address drops the two byte bits, so offsets below are shifted by 2.
  assign req_tag   = req_addr_q[addr_len-3 -: tag_len];
  assign req_index = req_addr_q[offset_len-2 +: index_len];
  assign req_sel   = req_addr_q[sel_w-1:0];
  assign cpu_index = bus.cpu_addr[offset_len +: index_len];
  assign rd_line   = bus.data_out;
  assign hit       = bus.status_out[0] && (bus.tag_out == req_tag);
  assign dirty     = bus.status_out[0] && bus.status_out[1];

  always_comb begin
    merged_rd              = rd_line;
    merged_rd[req_sel]     = req_wdata_q;
    merged_refill          = refill_q;
    merged_refill[req_sel] = req_wdata_q;
  end

  always_comb begin
    state_d       = state_q;
    bus.cpu_ready = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.tag_we    = 1'b0;
    bus.tag_addr  = req_index;
    bus.tag_in    = req_tag;
    bus.status_in = 3'b001;
    bus.data_we   = 1'b0;
    bus.data_addr = req_index;
    bus.data_in   = merged_rd;
    bus.mem_req   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cpu_ready = !rst;
        bus.tag_addr  = cpu_index;
        bus.data_addr = cpu_index;
        if (bus.cpu_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          if (req_we_q) begin
            bus.data_we   = 1'b1;
            bus.tag_we    = 1'b1;
            bus.status_in = 3'b011;
          end
          state_d = RESP;
        end else begin
          state_d = dirty ? WB : REFILL;
        end
      end
      WB: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) state_d = REFILL;
      end
      REFILL: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) state_d = FILL;
      end
      FILL: begin
        bus.data_we   = 1'b1;
        bus.data_in   = req_we_q ? merged_refill : refill_q;
        bus.tag_we    = 1'b1;
        bus.status_in = req_we_q ? 3'b011 : 3'b001;
        state_d       = RESP;
      end
      RESP: begin
        bus.cpu_valid = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      refill_q    <= '0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_req) begin
            req_we_q    <= bus.cpu_we;
            req_addr_q  <= bus.cpu_addr[addr_len-1:2];
            req_wdata_q <= bus.cpu_wdata;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (hit_q != {cnt_w{1'b1}}) hit_q <= hit_q + 1'b1;
            if (!req_we_q) rdata_q <= rd_line[req_sel];
          end else begin
            if (miss_q != {cnt_w{1'b1}}) miss_q <= miss_q + 1'b1;
            // The victim line and its tag are only readable now; keep them for the writeback.
            mem_wdata_q <= rd_line;
            mem_we_q    <= dirty;
            mem_addr_q  <= dirty ? {bus.tag_out, req_index} : {req_tag, req_index};
          end
        end
        WB: begin
          if (bus.mem_ack) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= {req_tag, req_index};
          end
        end
        REFILL: begin
          if (bus.mem_ack) refill_q <= bus.mem_rdata;
        end
        FILL: begin
          if (!req_we_q) rdata_q <= refill_q[req_sel];
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.hit_cnt   = 32'(hit_q);
  assign bus.miss_cnt  = 32'(miss_q);
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: RAM and memory models, vector table, and reset/back-to-back sequences.
module tb_cache_ctrl;
  localparam int TAG = 13, IDX = 10, OFF = 4;
  localparam int A = TAG + IDX + OFF;
  localparam int L = 128;
  localparam int LA = TAG + IDX;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_ctrl_if #(.tag_len(TAG), .index_len(IDX), .offset_len(OFF)) bus();
  cache_ctrl #(.tag_len(TAG), .index_len(IDX), .offset_len(OFF), .cnt_w(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [L-1:0] gen_line(input logic [LA-1:0] la);
    logic [3:0][31:0] w;
    for (int i = 0; i < 4; i++) w[i] = {4'hA, 4'(i), 1'b0, la};
    if (la == 23'd1) w[0] = 32'hDEADBEEF;
    return w;
  endfunction

  function automatic logic [L-1:0] set_word(input logic [L-1:0] line, input logic [1:0] i, input logic [31:0] v);
    logic [3:0][31:0] w;
    w = line;
    w[i] = v;
    return w;
  endfunction

  function automatic logic [31:0] get_word(input logic [L-1:0] line, input logic [1:0] i);
    logic [3:0][31:0] w;
    w = line;
    return w[i];
  endfunction

  function automatic logic [A-1:0] mk(input logic [TAG-1:0] t, input logic [IDX-1:0] x, input logic [1:0] wd);
    return {t, x, wd, 2'b00};
  endfunction

  function automatic logic [LA-1:0] la(input logic [TAG-1:0] t, input logic [IDX-1:0] x);
    return {t, x};
  endfunction

  // Status/tag RAM and data RAM: 1-cycle synchronous read
  logic [TAG-1:0] tag_ram [1024];
  logic [2:0]     stat_ram[1024];
  logic [L-1:0]   data_ram[1024];
  int n_tag_we = 0;
  int n_data_we = 0;

  always @(posedge clk) begin
    if (bus.tag_we) begin
      tag_ram[bus.tag_addr]  <= bus.tag_in;
      stat_ram[bus.tag_addr] <= bus.status_in;
      n_tag_we <= n_tag_we + 1;
    end
    if (bus.data_we) begin
      data_ram[bus.data_addr] <= bus.data_in;
      n_data_we <= n_data_we + 1;
    end
    bus.tag_out    <= tag_ram[bus.tag_addr];
    bus.status_out <= stat_ram[bus.tag_addr];
    bus.data_out   <= data_ram[bus.data_addr];
  end

  // Memory responder: acks after mem_lat cycles of mem_req, logs each transaction
  int mem_lat = 3;
  int wait_cnt = 0;
  int unstable = 0;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;
  logic [LA+L:0] prev_snap = '0;
  logic          log_we[$];
  logic [LA-1:0] log_addr[$];
  logic [L-1:0]  log_wdata[$];

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_req = 1'b0;
        wait_cnt = 0;
        bus.mem_ack = 1'b0;
      end else begin
        if (bus.mem_req && prev_req && !prev_ack && ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== prev_snap))
          unstable++;
        bus.mem_ack = 1'b0;
        if (bus.mem_req) begin
          wait_cnt++;
          if (wait_cnt >= mem_lat) begin
            bus.mem_ack = 1'b1;
            wait_cnt = 0;
            log_we.push_back(bus.mem_we);
            log_addr.push_back(bus.mem_addr);
            log_wdata.push_back(bus.mem_wdata);
            if (!bus.mem_we) bus.mem_rdata = gen_line(bus.mem_addr);
          end
        end else begin
          wait_cnt = 0;
        end
        prev_req = bus.mem_req;
        prev_ack = bus.mem_ack;
        prev_snap = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
      end
    end
  end

  task automatic access(input logic we, input logic [A-1:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output logic rdy_after);
    int g = 0;
    while (!bus.cpu_ready && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wd;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    lat = 1;
    while (!bus.cpu_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = bus.cpu_rdata;
    @(posedge clk);
    #1;
    rdy_after = bus.cpu_ready;
  endtask

  typedef struct {
    logic         we;
    logic [A-1:0] addr;
    logic [31:0]  wdata;
    logic [31:0]  exp_rdata;
    int           exp_lat;
    int           exp_mtx;
    logic [2:0]   exp_stat;
    logic [L-1:0] exp_line;
    int           exp_hit;
    int           exp_miss;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] rd;
  int lat;
  logic rdy;
  int ntx0;
  int ntag0, ndata0;
  logic [5:0] vpat, rpat;
  logic [L-1:0] l01, l51, l51b, l72;
  logic [IDX-1:0] vidx;

  initial begin
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      tag_ram[i]  <= '0;
      stat_ram[i] <= '0;
      data_ram[i] <= '0;
    end

    l01  = gen_line(la(0, 1));
    l51  = gen_line(la(5, 1));
    l51b = set_word(l51, 2'd0, 32'h0BADC0DE);
    l72  = set_word(gen_line(la(7, 2)), 2'd3, 32'hCAFEF00D);
    //          we    addr         wdata         rdata                lat mtx stat    line                               hit miss
    vecs[0]  = '{1'b0, mk(0, 1, 0), 32'h0,        32'hDEADBEEF,        6,  1, 3'b001, l01,                               0,  1};
    vecs[1]  = '{1'b0, mk(0, 1, 0), 32'h0,        32'hDEADBEEF,        2,  0, 3'b001, l01,                               1,  1};
    vecs[2]  = '{1'b1, mk(0, 1, 2), 32'h12345678, 32'h0,               2,  0, 3'b011, set_word(l01, 2'd2, 32'h12345678), 2,  1};
    vecs[3]  = '{1'b0, mk(0, 1, 2), 32'h0,        32'h12345678,        2,  0, 3'b011, set_word(l01, 2'd2, 32'h12345678), 3,  1};
    vecs[4]  = '{1'b0, mk(5, 1, 1), 32'h0,        get_word(l51, 2'd1), 9,  2, 3'b001, l51,                               3,  2};
    vecs[5]  = '{1'b1, mk(7, 2, 3), 32'hCAFEF00D, 32'h0,               6,  1, 3'b011, l72,                               3,  3};
    vecs[6]  = '{1'b0, mk(7, 2, 3), 32'h0,        32'hCAFEF00D,        2,  0, 3'b011, l72,                               4,  3};
    vecs[7]  = '{1'b0, mk(5, 1, 1), 32'h0,        get_word(l51, 2'd1), 2,  0, 3'b001, l51,                               5,  3};
    vecs[8]  = '{1'b1, mk(5, 1, 0), 32'h0BADC0DE, 32'h0,               2,  0, 3'b011, l51b,                              6,  3};
    vecs[9]  = '{1'b0, mk(5, 1, 0), 32'h0,        32'h0BADC0DE,        2,  0, 3'b011, l51b,                              7,  3};
    vecs[10] = '{1'b0, mk(7, 2, 3), 32'h0,        32'hCAFEF00D,        2,  0, 3'b011, l72,                               7,  3};
    vecs[11] = '{1'b0, mk(5, 1, 1), 32'h0,        get_word(l51, 2'd1), 2,  0, 3'b011, l51b,                              7,  3};

    #2;
    check("rst_ready_low", bus.cpu_ready, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_valid", bus.cpu_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ready_high", bus.cpu_ready, 1);
    check("rst_counters", {bus.hit_cnt, bus.miss_cnt}, 0);
    check("rst_rdata", bus.cpu_rdata, 0);
    check("rst_mem_regs", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);

    for (int i = 0; i < 12; i++) begin
      ntx0 = log_we.size();
      vidx = vecs[i].addr[OFF +: IDX];
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, rdy);
      if (!vecs[i].we) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_ready_after", i), rdy, 1);
      check($sformatf("v%0d_mem_txns", i), log_we.size() - ntx0, vecs[i].exp_mtx);
      check($sformatf("v%0d_status", i), stat_ram[vidx], vecs[i].exp_stat);
      check($sformatf("v%0d_tag", i), tag_ram[vidx], vecs[i].addr[A-1 -: TAG]);
      check($sformatf("v%0d_line", i), data_ram[vidx], vecs[i].exp_line);
      check($sformatf("v%0d_hit_cnt", i), bus.hit_cnt, vecs[i].exp_hit);
      check($sformatf("v%0d_miss_cnt", i), bus.miss_cnt, vecs[i].exp_miss);
      if (i == 0 && log_we.size() > ntx0) begin
        check("cold_read_we", log_we[ntx0], 0);
        check("cold_read_addr", log_addr[ntx0], la(0, 1));
      end
      if (i == 4 && log_we.size() > ntx0 + 1) begin
        check("wb_we", log_we[ntx0], 1);
        check("wb_addr", log_addr[ntx0], la(0, 1));
        check("wb_line", log_wdata[ntx0], set_word(l01, 2'd2, 32'h12345678));
        check("wb_refill_we", log_we[ntx0 + 1], 0);
        check("wb_refill_addr", log_addr[ntx0 + 1], la(5, 1));
      end
    end

    // Request held high through RESP: the second load is taken only in the following IDLE cycle
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = mk(5, 1, 1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      vpat[c] = bus.cpu_valid;
      rpat[c] = bus.cpu_ready;
      if (c == 3) bus.cpu_req = 1'b0;
    end
    check("b2b_valid_pattern", vpat, 6'b010010);
    check("b2b_ready_pattern", rpat, 6'b100100);
    check("b2b_rdata", bus.cpu_rdata, get_word(l51, 2'd1));

    // Reset during REFILL with the ack still outstanding
    mem_lat = 20;
    ntag0 = n_tag_we;
    ndata0 = n_data_we;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = mk(9, 3, 0);
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_req_before", bus.mem_req, 1);
    check("mid_rst_refill_addr", bus.mem_addr, la(9, 3));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_req_async", bus.mem_req, 0);
    check("mid_rst_ready_low", bus.cpu_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ready_after", bus.cpu_ready, 1);
    check("mid_rst_no_tag_we", n_tag_we - ntag0, 0);
    check("mid_rst_no_data_we", n_data_we - ndata0, 0);
    check("mid_rst_status_untouched", stat_ram[3], 0);
    check("mid_rst_counters", {bus.hit_cnt, bus.miss_cnt}, 0);
    mem_lat = 3;

    access(1'b0, mk(9, 3, 0), 32'h0, rd, lat, rdy);
    check("post_rst_rdata", rd, get_word(gen_line(la(9, 3)), 2'd0));
    check("post_rst_latency", lat, 6);
    check("post_rst_miss_cnt", bus.miss_cnt, 1);
    check("post_rst_status", stat_ram[3], 3'b001);
    check("mem_stable", unstable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
